// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave responder
package spi_pkg;

  localparam int SPI_DATA_W = 32;

  // Mode 0: SCK idles low, data sampled on the leading edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_responder_if.sv
// rtl/spi_slave_responder_if.sv - TX/RX word streams and status flags of the SPI slave
interface spi_slave_responder_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic [DATA_W-1:0] tx_data_i;
  logic              tx_vld_i;
  logic              tx_rdy_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_vld_o;
  logic              rx_rdy_i;
  logic              busy_o;
  logic              ovf_o;
  logic              udr_o;
  logic              frame_err_o;

  modport slave (
    input  tx_data_i,
    input  tx_vld_i,
    output tx_rdy_o,
    output rx_data_o,
    output rx_vld_o,
    input  rx_rdy_i,
    output busy_o,
    output ovf_o,
    output udr_o,
    output frame_err_o
  );

  modport master (
    output tx_data_i,
    output tx_vld_i,
    input  tx_rdy_o,
    input  rx_data_o,
    input  rx_vld_o,
    output rx_rdy_i,
    input  busy_o,
    input  ovf_o,
    input  udr_o,
    input  frame_err_o
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - optional 2-flop synchronizer (SPI_SLAVE_SYNC_EN) plus registered rise/fall detect
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic level;
  logic prev_q;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], pin_i};
    end
  end

  assign level = sync_q[1];
`else
  assign level = pin_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= level;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - oversampling SPI mode-0 slave with RX/TX word streams
// SPI_SLAVE_SYNC_EN adds 2-flop synchronizers on SCK, CS and MOSI.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_sdi_i,
  output logic                  spi_sdo_o,
  spi_slave_responder_if.slave  bus
);

  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  spi_state_e state_q, state_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall, sdi_s;
  logic sample_edge, shift_edge;
  logic frame_start, frame_end, active_run;
  logic word_done, hold_write, hold_take, udr_evt;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-2:0] rx_shift_q;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] hold_q;
  logic              rx_vld_q, hold_full_q;
  logic              ovf_q, udr_q, ferr_q;
  logic              reload_pend_q, commit_pend_q, commit_udr_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (spi_sck_i ^ SPI_CPOL),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (spi_cs_n_i),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] sdi_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdi_sync_q <= 2'b00;
    end else begin
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
    end
  end

  assign sdi_s = sdi_sync_q[1];
`else
  assign sdi_s = spi_sdi_i;
`endif

  assign sample_edge = SPI_CPHA ? sck_fall : sck_rise;
  assign shift_edge  = SPI_CPHA ? sck_rise : sck_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active_run = (state_q == ST_ACTIVE) && !cs_rise;
  assign word_done  = active_run && sample_edge && (bit_cnt_q == LAST);
  assign rx_word    = {rx_shift_q, sdi_s};
  assign hold_write = bus.tx_vld_i && !hold_full_q;

  // Mid-frame word starts are committed on the first sample edge of the new
  // word, so the trailing SCK edge of a frame's last word consumes nothing.
  assign hold_take = (frame_start && hold_full_q) ||
                     (active_run && sample_edge && commit_pend_q && !commit_udr_q);
  assign udr_evt   = (frame_start && !hold_full_q) ||
                     (active_run && sample_edge && commit_pend_q && commit_udr_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (hold_write) begin
        hold_q <= bus.tx_data_i;
      end
      if (hold_write) begin
        hold_full_q <= 1'b1;
      end else if (hold_take) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      reload_pend_q <= 1'b0;
      commit_pend_q <= 1'b0;
      commit_udr_q  <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (frame_start) begin
        tx_shift_q    <= hold_full_q ? hold_q : '0;
        bit_cnt_q     <= '0;
        reload_pend_q <= 1'b0;
        commit_pend_q <= 1'b0;
      end else if (frame_end) begin
        tx_shift_q    <= '0;
        bit_cnt_q     <= '0;
        reload_pend_q <= 1'b0;
        commit_pend_q <= 1'b0;
        ferr_q        <= (bit_cnt_q != '0);
      end else if (active_run) begin
        if (sample_edge) begin
          rx_shift_q    <= rx_word[DATA_W-2:0];
          commit_pend_q <= 1'b0;
          if (bit_cnt_q == LAST) begin
            bit_cnt_q     <= '0;
            reload_pend_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        if (shift_edge) begin
          if (reload_pend_q) begin
            tx_shift_q    <= hold_full_q ? hold_q : '0;
            reload_pend_q <= 1'b0;
            commit_pend_q <= 1'b1;
            commit_udr_q  <= !hold_full_q;
          end else begin
            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  // Accepting in the completion cycle frees the slot for the new word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udr_q     <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udr_q <= udr_evt;
      if (word_done) begin
        if (!rx_vld_q || bus.rx_rdy_i) begin
          rx_data_q <= rx_word;
          rx_vld_q  <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (rx_vld_q && bus.rx_rdy_i) begin
        rx_vld_q <= 1'b0;
      end
    end
  end

  assign spi_sdo_o       = tx_shift_q[DATA_W-1];
  assign bus.tx_rdy_o    = !hold_full_q;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.rx_vld_o    = rx_vld_q;
  assign bus.busy_o      = (state_q == ST_ACTIVE);
  assign bus.ovf_o       = ovf_q;
  assign bus.udr_o       = udr_q;
  assign bus.frame_err_o = ferr_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - scoreboard bench driving SPI mode-0 frames into the slave
module tb_spi_slave_responder;
  import spi_pkg::*;

  logic clk, rst, sck, cs_n, sdi, sdo;

  spi_slave_responder_if #(.DATA_W(SPI_DATA_W)) bus ();

  spi_slave_responder #(.DATA_W(SPI_DATA_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .spi_sck_i  (sck),
    .spi_cs_n_i (cs_n),
    .spi_sdi_i  (sdi),
    .spi_sdo_o  (sdo),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  int n_vld, n_hs, n_udr, n_ovf, n_ferr;
  int v0, h0, u0, o0, f0;
  logic [31:0] exp_rx_q[$];
  logic [31:0] exp_miso_q[$];
  logic [31:0] cap_q[$];
  logic [31:0] scratch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.rx_vld_o) n_vld++;
      if (bus.udr_o) n_udr++;
      if (bus.ovf_o) n_ovf++;
      if (bus.frame_err_o) n_ferr++;
      if (bus.rx_vld_o && bus.rx_rdy_i) begin
        n_hs++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=%h required=none", bus.rx_data_o);
        end else begin
          chk("rx_word", bus.rx_data_o, exp_rx_q.pop_front());
        end
      end
      if (cap_q.size() != 0 && exp_miso_q.size() != 0)
        chk("miso_word", cap_q.pop_front(), exp_miso_q.pop_front());
    end
  endtask

  task automatic snap();
    v0 = n_vld; h0 = n_hs; u0 = n_udr; o0 = n_ovf; f0 = n_ferr;
  endtask

  task automatic tx_write(input logic [31:0] d);
    int t = 0;
    while (!bus.tx_rdy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_rdy_o) begin
      checks++;
      errors++;
      $display("FAIL tx_rdy_timeout actual=0 required=1");
    end
    bus.tx_data_i = d;
    bus.tx_vld_i  = 1'b1;
    @(negedge clk);
    bus.tx_vld_i  = 1'b0;
  endtask

  task automatic spi_bits(input logic [31:0] d, input int nbits, output logic [31:0] miso);
    miso = '0;
    for (int i = 31; i > 31 - nbits; i--) begin
      sdi = d[i];
      tick(4);
      miso = {miso[30:0], sdo};
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [31:0] d, input bit expect_rx, input logic [31:0] exp_miso);
    logic [31:0] m;
    if (expect_rx) exp_rx_q.push_back(d);
    exp_miso_q.push_back(exp_miso);
    spi_bits(d, 32, m);
    cap_q.push_back(m);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_sdo"},     32'(sdo), 32'd0);
    chk({tag, "_rx_data"}, bus.rx_data_o, 32'd0);
    chk({tag, "_rx_vld"},  32'(bus.rx_vld_o), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy_o), 32'd0);
    chk({tag, "_ovf"},     32'(bus.ovf_o), 32'd0);
    chk({tag, "_udr"},     32'(bus.udr_o), 32'd0);
    chk({tag, "_ferr"},    32'(bus.frame_err_o), 32'd0);
    chk({tag, "_tx_rdy"},  32'(bus.tx_rdy_o), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    n_vld = 0; n_hs = 0; n_udr = 0; n_ovf = 0; n_ferr = 0;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    bus.tx_data_i = '0; bus.tx_vld_i = 1'b0; bus.rx_rdy_i = 1'b1;
    fork
      monitor();
    join_none
    tick(3);
    reset_vals("rst");
    rst = 1'b0;
    tick(2);

    // single word, TX preloaded
    snap();
    tx_write(32'hDEAD_BEEF);
    chk("t1_tx_rdy_full", 32'(bus.tx_rdy_o), 32'd0);
    cs_begin();
    chk("t1_busy", 32'(bus.busy_o), 32'd1);
    chk("t1_tx_rdy_loaded", 32'(bus.tx_rdy_o), 32'd1);
    xfer(32'hA5A5_1234, 1'b1, 32'hDEAD_BEEF);
    cs_end();
    chk("t1_vld_cycles", 32'(n_vld - v0), 32'd1);
    chk("t1_udr", 32'(n_udr - u0), 32'd0);
    chk("t1_busy_end", 32'(bus.busy_o), 32'd0);

    // back-to-back words in one frame
    snap();
    tx_write(32'h1111_1111);
    cs_begin();
    tx_write(32'h2222_2222);
    xfer(32'h0000_0001, 1'b1, 32'h1111_1111);
    xfer(32'h8000_0000, 1'b1, 32'h2222_2222);
    cs_end();
    chk("t2_udr", 32'(n_udr - u0), 32'd0);
    chk("t2_hs", 32'(n_hs - h0), 32'd2);

    // consumer stalled: second word dropped
    snap();
    bus.rx_rdy_i = 1'b0;
    cs_begin();
    xfer(32'h0F0F_0F0F, 1'b1, 32'h0000_0000);
    xfer(32'h1234_5678, 1'b0, 32'h0000_0000);
    cs_end();
    chk("t3_ovf", 32'(n_ovf - o0), 32'd1);
    chk("t3_rx_vld", 32'(bus.rx_vld_o), 32'd1);
    chk("t3_rx_data", bus.rx_data_o, 32'h0F0F_0F0F);
    chk("t3_udr", 32'(n_udr - u0), 32'd2);
    bus.rx_rdy_i = 1'b1;
    tick(2);
    chk("t3_rx_vld_drop", 32'(bus.rx_vld_o), 32'd0);

    // underrun
    snap();
    cs_begin();
    chk("t4_tx_rdy_mid", 32'(bus.tx_rdy_o), 32'd1);
    xfer(32'hC3C3_C3C3, 1'b1, 32'h0000_0000);
    cs_end();
    chk("t4_udr", 32'(n_udr - u0), 32'd1);
    chk("t4_tx_rdy_end", 32'(bus.tx_rdy_o), 32'd1);

    // CS raised after 13 bits, then a clean word
    snap();
    cs_begin();
    spi_bits(32'hFFFF_FFFF, 13, scratch);
    cs_end();
    chk("t5_ferr", 32'(n_ferr - f0), 32'd1);
    chk("t5_no_vld", 32'(n_vld - v0), 32'd0);
    cs_begin();
    xfer(32'h5A5A_5A5A, 1'b1, 32'h0000_0000);
    cs_end();
    chk("t5_vld_after", 32'(n_hs - h0), 32'd1);
    chk("t5_ferr_after", 32'(n_ferr - f0), 32'd1);

    // reset mid-frame at bit 20
    tx_write(32'h7777_7777);
    cs_begin();
    tx_write(32'h8888_8888);
    spi_bits(32'hFFFF_0000, 20, scratch);
    rst = 1'b1;
    #1;
    reset_vals("t6");
    cs_n = 1'b1;
    sck = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    snap();
    tx_write(32'h1357_9BDF);
    cs_begin();
    xfer(32'hC0FF_EE11, 1'b1, 32'h1357_9BDF);
    cs_end();
    chk("t6_hs", 32'(n_hs - h0), 32'd1);
    chk("t6_udr", 32'(n_udr - u0), 32'd0);

    tick(20);
    chk("rx_queue_left", 32'(exp_rx_q.size()), 32'd0);
    chk("miso_queue_left", 32'(exp_miso_q.size()), 32'd0);
    chk("cap_queue_left", 32'(cap_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
